rgb_rx_capture: RTL and testbench
=================================

Name: rgb_rx_capture

Overview:
- Receive side of the parallel RGB/DE/VS LCD-style video interface.
- Samples a 24-bit pixel bus qualified by DE, and frames it with VS.
- Buffers the pixels in a small FIFO, since the source cannot be stalled.
- Presents them as a valid/ready stream with start-of-frame and end-of-line markers.
- Flags overflow and frame-geometry errors, so an upstream camera/test source can feed the CNN datapath.

Parameters:
- H_ACTIVE, 800: expected pixels per active line.
- V_ACTIVE, 480: expected active lines per frame.
- FIFO_DEPTH, 16: FIFO entries; power of 2, minimum 4.
- VS_POL, 1: 1 = VS active-high, 0 = VS active-low.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rgb  in  24  pixel data, {b[23:16], g[15:8], r[7:0]}.
- i_de  in  1  data enable; pixel valid when high.
- i_vs  in  1  vertical sync, polarity per VS_POL.
- i_clr  in  1  synchronous clear of sticky flags and error count.
- o_rgb  out  24  output pixel.
- o_sof  out  1  first pixel of frame, qualified by o_data_vld.
- o_eol  out  1  last pixel of line, qualified by o_data_vld.
- o_data_vld  out  1  output pixel valid.
- i_data_ready  in  1  consumer ready; transfer when vld & ready.
- o_overflow  out  1  sticky, FIFO overflow occurred.
- o_size_err  out  1  sticky, line or frame size mismatch.
- o_frame_done  out  1  one-cycle pulse at the end of every received frame.
- o_err_cnt  out  16  error event count (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; counters 0.
- Input stage 1: i_rgb, i_de and normalized VS (vs_n = i_vs ^ ~VS_POL) registered every cycle.
- Input stage 2: stage-1 values registered again.
- vs_edge: stage-1 vs_n high & stage-2 vs_n low.
- eol: stage-2 DE high & stage-1 DE low.
- FIFO entry = {sof, eol, rgb}, 26 bits.
- Write condition: stage-2 DE high & state FRAME.
- sof = first write since the last vs_edge.
- FIFO is first-word fall-through. o_data_vld = not empty, and outputs show the head entry.
- Latency: pixel sampled at edge N is visible on outputs after edge N+3 when the FIFO was empty.
- Full boundary: a write with the FIFO full is accepted only if a read occurs in the same cycle; otherwise it is an overflow.
- Simultaneous read and write when empty: the write lands and is visible next cycle; the count is unchanged only when both actually occur.
- FSM:
  - IDLE: on vs_edge -> FRAME; clear pixel and line counters.
  - FRAME: pixels written. On overflow: drop the pixel, set o_overflow, -> DROP.
  - FRAME on vs_edge: pulse o_frame_done. If line_cnt != V_ACTIVE, set o_size_err. Clear counters; stay FRAME.
  - DROP: no writes; FIFO keeps draining. On vs_edge -> FRAME (no frame_done pulse, counters cleared).
- Pixel counter (11 bits, saturating):
  - Increments per stage-2 DE pixel in FRAME.
  - On eol: if count+1 != H_ACTIVE, set o_size_err; reset count; line_cnt++ (10 bits, saturating).
- DE high at vs_edge: that pixel counts in the new frame.
- A DE pixel in IDLE is ignored; no error.
- i_clr: clears o_overflow, o_size_err and o_err_cnt next cycle. Does not affect FIFO or FSM.
- If i_clr coincides with an error event, the set wins.
- Reset mid-frame: FIFO flushed, state IDLE. The next partial frame is not captured until a fresh vs_edge.

Optional Feature:
- Macro: RGB_RX_ERR_CNT_EN.
- Defined: o_err_cnt increments by 1 on each overflow transition into DROP and each o_size_err set-event. Both events in one cycle count as 2. Saturates at 16'hFFFF; cleared by i_clr or reset.
- Undefined: counter logic absent; o_err_cnt tied to 16'h0000.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, i_data_ready=1; VS pulse, then 2 lines of 4 pixels 0x000001..0x000008 -> 8 beats in order; o_sof on 0x000001; o_eol on 0x000004 and 0x000008; o_frame_done pulses at next VS edge; no error flags.
- Single pixel 0xABCDEF after VS edge, FIFO empty -> o_data_vld high and o_rgb=0xABCDEF exactly 3 edges after the sampling edge.
- FIFO_DEPTH=4, i_data_ready=0, 6-pixel line -> 4 entries held, o_overflow=1, state DROP. Raise ready -> 4 pixels drained; further pixels ignored until next VS, then the new frame's first pixel has o_sof=1.
- Line of 3 pixels with H_ACTIVE=4 -> o_size_err=1. Frame of 3 lines with V_ACTIVE=2 -> o_size_err set at VS edge. i_clr -> flags 0 next cycle.
- FIFO full with i_data_ready=1 and a write in the same cycle -> no overflow, count stays full, data order preserved.
- Assert i_rst_n low mid-line with FIFO at 3 entries -> o_data_vld=0 immediately. After release, DE pixels before a VS edge are not output.
- With RGB_RX_ERR_CNT_EN: one overflow and two short lines -> o_err_cnt=3. Without the macro -> o_err_cnt=0.

Source files
------------

// File: rtl/rgb_rx_capture.sv
// Receive side of a parallel RGB/DE/VS video port: two-stage input sampling, frame FSM,
// FWFT pixel FIFO with valid/ready output. Optional error counter: define RGB_RX_ERR_CNT_EN.
module rgb_rx_capture #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter bit VS_POL     = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_rgb,
  input  logic        i_de,
  input  logic        i_vs,
  input  logic        i_clr,
  output logic [23:0] o_rgb,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_data_vld,
  input  logic        i_data_ready,
  output logic        o_overflow,
  output logic        o_size_err,
  output logic        o_frame_done,
  output logic [15:0] o_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;
  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] rgb;
  } entry_t;

  logic [23:0] s1_rgb, s2_rgb;
  logic        s1_de, s2_de, s1_vs, s2_vs;
  logic        vs_n;

  assign vs_n = VS_POL ? i_vs : ~i_vs;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_rgb <= '0; s1_de <= 1'b0; s1_vs <= 1'b0;
      s2_rgb <= '0; s2_de <= 1'b0; s2_vs <= 1'b0;
    end else begin
      s1_rgb <= i_rgb;  s1_de <= i_de;  s1_vs <= vs_n;
      s2_rgb <= s1_rgb; s2_de <= s1_de; s2_vs <= s1_vs;
    end
  end

  state_t          state;
  entry_t          wr_q;
  logic            wr_vld_q;
  logic            sof_pend;
  logic [10:0]     pix_cnt, base_pix, pix_inc;
  logic [9:0]      line_cnt, base_line, line_inc;
  logic            vs_edge, eol, gen, line_err, frame_err;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            empty, full, rd_fire, fifo_wr, wr_fire, ovf;

  assign vs_edge = s1_vs & ~s2_vs;
  assign eol     = s2_de & ~s1_de;
  // A DE pixel coinciding with the VS edge already belongs to the new frame.
  assign gen     = s2_de & ((state == FRAME) | vs_edge);

  assign base_pix  = vs_edge ? '0 : pix_cnt;
  assign base_line = vs_edge ? '0 : line_cnt;
  assign pix_inc   = (base_pix == '1)  ? base_pix  : base_pix + 11'd1;
  assign line_inc  = (base_line == '1) ? base_line : base_line + 10'd1;
  assign line_err  = gen & eol & (pix_inc != 11'(H_ACTIVE));
  assign frame_err = vs_edge & (state == FRAME) & (line_cnt != 10'(V_ACTIVE));

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_fire = ~empty & i_data_ready;
  // Entries staged before an overflow are discarded once the FSM has left FRAME.
  assign fifo_wr = wr_vld_q & (state == FRAME);
  assign ovf     = fifo_wr & full & ~rd_fire;
  assign wr_fire = fifo_wr & ~ovf;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      wr_q         <= '0;
      wr_vld_q     <= 1'b0;
      sof_pend     <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      o_size_err   <= 1'b0;
    end else begin
      o_frame_done <= vs_edge & (state == FRAME);
      wr_vld_q     <= gen;
      if (gen) wr_q <= '{sof: vs_edge | sof_pend, eol: eol, rgb: s2_rgb};

      if (gen)          sof_pend <= 1'b0;
      else if (vs_edge) sof_pend <= 1'b1;

      if (gen) begin
        if (eol) begin
          pix_cnt  <= '0;
          line_cnt <= line_inc;
        end else begin
          pix_cnt  <= pix_inc;
          line_cnt <= base_line;
        end
      end else if (vs_edge) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end

      if (vs_edge)  state <= FRAME;
      else if (ovf) state <= DROP;

      o_overflow <= ovf | (o_overflow & ~i_clr);
      o_size_err <= line_err | frame_err | (o_size_err & ~i_clr);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is carried by count, and the outputs are gated.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_q;
  end

  assign head       = mem[rd_ptr];
  assign o_data_vld = ~empty;
  assign o_rgb      = empty ? '0 : head.rgb;
  assign o_sof      = ~empty & head.sof;
  assign o_eol      = ~empty & head.eol;

`ifdef RGB_RX_ERR_CNT_EN
  logic [1:0]  n_ev;
  logic [15:0] err_base;
  logic [16:0] err_sum;

  assign n_ev     = {1'b0, ovf} + {1'b0, line_err} + {1'b0, frame_err};
  assign err_base = i_clr ? 16'h0000 : o_err_cnt;
  assign err_sum  = {1'b0, err_base} + {15'd0, n_ev};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) o_err_cnt <= '0;
    else          o_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  assign o_err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_rgb_rx_capture.sv
// Directed self-checking bench for rgb_rx_capture with a small geometry (4x2) and a 4-deep FIFO.
module tb_rgb_rx_capture;
  logic        clk = 1'b0;
  logic        i_rst_n, i_de, i_vs, i_clr, i_data_ready;
  logic [23:0] i_rgb, o_rgb;
  logic        o_sof, o_eol, o_data_vld, o_overflow, o_size_err, o_frame_done;
  logic [15:0] o_err_cnt;

`ifdef RGB_RX_ERR_CNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  rgb_rx_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4), .VS_POL(1'b1)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_rgb(i_rgb), .i_de(i_de), .i_vs(i_vs), .i_clr(i_clr),
    .o_rgb(o_rgb), .o_sof(o_sof), .o_eol(o_eol), .o_data_vld(o_data_vld),
    .i_data_ready(i_data_ready), .o_overflow(o_overflow), .o_size_err(o_size_err),
    .o_frame_done(o_frame_done), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          fd_cnt   = 0;
  int          exp_err  = 0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];

  // Transfers and frame_done pulses are observed mid-cycle, between edges.
  always @(negedge clk) begin
    if (i_rst_n && o_data_vld && i_data_ready) got_q.push_back({o_sof, o_eol, o_rgb});
    if (o_frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vs_pulse();
    i_de = 1'b0;
    i_vs = 1'b1;
    step(2);
    i_vs = 1'b0;
    step(2);
  endtask

  task automatic send_line(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      i_rgb = base + 24'(i);
      i_de  = 1'b1;
      step(1);
    end
    i_de  = 1'b0;
    i_rgb = '0;
    step(3);
  endtask

  task automatic expect_px(input logic sof, input logic eol, input logic [23:0] rgb);
    exp_q.push_back({sof, eol, rgb});
  endtask

  task automatic compare_q(input string tag);
    int n;
    check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clr_flags();
    i_clr = 1'b1;
    step(1);
    i_clr = 1'b0;
    exp_err = 0;
  endtask

  function automatic logic [31:0] exp_cnt();
    return ERR_ON ? 32'(exp_err) : 32'd0;
  endfunction

  initial begin
    i_rst_n = 1'b0; i_de = 1'b0; i_vs = 1'b0; i_clr = 1'b0; i_data_ready = 1'b1; i_rgb = '0;
    step(3);
    check("rst_vld", o_data_vld, 0);
    check("rst_outs", {o_rgb, o_sof, o_eol}, 0);
    check("rst_flags", {o_overflow, o_size_err, o_frame_done}, 0);
    check("rst_errcnt", o_err_cnt, 0);
    i_rst_n = 1'b1;
    step(2);

    // Nominal 4x2 frame
    vs_pulse();
    check("no_fd_from_idle", fd_cnt, 0);
    send_line(24'h000001, 4);
    send_line(24'h000005, 4);
    step(6);
    for (int i = 1; i <= 8; i++) expect_px(i == 1, (i == 4) || (i == 8), 24'(i));
    compare_q("frame1");
    vs_pulse();
    check("frame_done", fd_cnt, 1);
    check("frame1_flags", {o_overflow, o_size_err}, 0);
    check("frame1_errcnt", o_err_cnt, 0);

    // Latency: sampled at edge N, visible after edge N+3
    i_rgb = 24'hABCDEF;
    i_de  = 1'b1;
    step(1);
    i_de  = 1'b0;
    i_rgb = '0;
    check("lat_n0", o_data_vld, 0);
    step(1);
    check("lat_n1", o_data_vld, 0);
    step(1);
    check("lat_n2", o_data_vld, 0);
    step(1);
    check("lat_n3_vld", o_data_vld, 1);
    check("lat_n3_px", {o_sof, o_eol, o_rgb}, {2'b11, 24'hABCDEF});
    step(4);
    got_q.delete();
    check("one_px_line_err", o_size_err, 1);
    exp_err = 1;
    check("one_px_errcnt", o_err_cnt, exp_cnt());
    clr_flags();
    check("clr_flags", {o_overflow, o_size_err}, 0);
    check("clr_errcnt", o_err_cnt, 0);

    // Short line, then too many lines in the frame
    send_line(24'h000010, 3);
    check("short_line", o_size_err, 1);
    exp_err = 1;
    check("short_errcnt", o_err_cnt, exp_cnt());
    clr_flags();
    check("short_clr", o_size_err, 0);
    send_line(24'h000020, 4);
    send_line(24'h000030, 4);
    check("full_lines_ok", o_size_err, 0);
    vs_pulse();
    check("frame_size_err", o_size_err, 1);
    check("frame_done2", fd_cnt, 2);
    exp_err = 1;
    check("frame_errcnt", o_err_cnt, exp_cnt());
    step(4);
    got_q.delete();
    clr_flags();

    // Overflow: 6-pixel line into 4-deep FIFO with consumer stalled
    i_data_ready = 1'b0;
    send_line(24'h000100, 6);
    check("ovf_flag", o_overflow, 1);
    check("ovf_head", {o_data_vld, o_rgb}, {1'b1, 24'h000100});
    exp_err = 2;
    check("ovf_errcnt", o_err_cnt, exp_cnt());
    i_data_ready = 1'b1;
    step(8);
    expect_px(1'b1, 1'b0, 24'h000100);
    for (int i = 1; i < 4; i++) expect_px(1'b0, 1'b0, 24'h000100 + 24'(i));
    compare_q("ovf_drain");
    send_line(24'h000200, 4);
    step(4);
    check("drop_vld", o_data_vld, 0);
    compare_q("drop_ignored");
    vs_pulse();
    check("drop_no_fd", fd_cnt, 2);
    send_line(24'h000300, 4);
    step(6);
    for (int i = 0; i < 4; i++) expect_px(i == 0, i == 3, 24'h000300 + 24'(i));
    compare_q("after_drop");
    check("ovf_sticky", o_overflow, 1);
    clr_flags();

    // Full FIFO with simultaneous read and write
    i_data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_rgb = 24'h000400 + 24'(i);
      i_de  = 1'b1;
      step(1);
    end
    i_de  = 1'b0;
    i_rgb = '0;
    step(1);
    check("full_state", {o_data_vld, o_overflow, o_rgb}, {2'b10, 24'h000400});
    i_data_ready = 1'b1;
    step(10);
    check("full_rw_no_ovf", o_overflow, 0);
    for (int i = 0; i < 6; i++) expect_px(1'b0, i == 5, 24'h000400 + 24'(i));
    compare_q("full_rw");
    check("long_line_err", o_size_err, 1);
    exp_err = 1;
    check("long_errcnt", o_err_cnt, exp_cnt());
    clr_flags();

    // Reset mid-line with 3 entries held
    i_data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_rgb = 24'h000500 + 24'(i);
      i_de  = 1'b1;
      step(1);
    end
    check("pre_rst_vld", o_data_vld, 1);
    i_rst_n = 1'b0;
    #1;
    check("rst_async_vld", o_data_vld, 0);
    check("rst_async_rgb", o_rgb, 0);
    step(2);
    i_rst_n = 1'b1;
    i_data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_rgb = 24'h000700 + 24'(i);
      i_de  = 1'b1;
      step(1);
    end
    i_de  = 1'b0;
    i_rgb = '0;
    step(6);
    check("post_rst_vld", o_data_vld, 0);
    compare_q("post_rst_ignored");
    check("post_rst_flags", {o_overflow, o_size_err}, 0);
    exp_err = 0;
    vs_pulse();
    send_line(24'h000600, 4);
    step(6);
    for (int i = 0; i < 4; i++) expect_px(i == 0, i == 3, 24'h000600 + 24'(i));
    compare_q("post_rst_frame");
    check("post_rst_errcnt", o_err_cnt, exp_cnt());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
